// File: rtl/vc_arbiter_pkg.sv
// rtl/vc_arbiter_pkg.sv - shared encodings and constants for the VC pop arbiter
package vc_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SERVE0 = 2'd1,
    ARB_SERVE1 = 2'd2
  } arb_state_e;

  localparam int STARVE_LIMIT_DEF = 8;

  localparam int VC0 = 0;
  localparam int VC1 = 1;

endpackage

// File: rtl/vc_arbiter_if.sv
// rtl/vc_arbiter_if.sv - FIFO status and pop strobes between arbiter and VC/D FIFOs
interface vc_arbiter_if;

  logic vc0_empty;
  logic vc1_empty;
  logic d0_pause;
  logic d1_pause;
  logic pop_VC0;
  logic pop_VC1;

  modport master (
    input  vc0_empty,
    input  vc1_empty,
    input  d0_pause,
    input  d1_pause,
    output pop_VC0,
    output pop_VC1
  );

  modport slave (
    output vc0_empty,
    output vc1_empty,
    output d0_pause,
    output d1_pause,
    input  pop_VC0,
    input  pop_VC1
  );

endinterface

// File: rtl/vc_wait_counter.sv
// rtl/vc_wait_counter.sv - saturating wait counter flagging a starved VC
module vc_wait_counter
  import vc_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == LIM);

endmodule

// File: rtl/vc_arbiter.sv
// rtl/vc_arbiter.sv - weighted round-robin scheduler popping VC0/VC1 into the D0/D1 path
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int WEIGHT_W     = 4,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [WEIGHT_W-1:0] weight_vc0,
  input  logic [WEIGHT_W-1:0] weight_vc1,
  vc_arbiter_if.master        vc,
  output logic [1:0]          arb_state,
  output logic                starve_evt,
  output logic [CNT_W-1:0]    pops_vc0,
  output logic [CNT_W-1:0]    pops_vc1
);

  arb_state_e          state_q, state_d;
  logic [WEIGHT_W-1:0] burst_q, burst_d;
  logic [WEIGHT_W-1:0] w0_q, w0_d;
  logic [WEIGHT_W-1:0] w1_q, w1_d;
  logic                starve_q, starve_d;
  logic [CNT_W-1:0]    pops0_q, pops0_d;
  logic [CNT_W-1:0]    pops1_q, pops1_d;

  logic                blk;
  logic                pop0, pop1;
  logic [1:0]          hit, inc, clr;
  logic                serving1;
  logic                cur_empty, oth_empty, oth_hit;
  logic [WEIGHT_W-1:0] cur_w, burst_inc;
  arb_state_e          oth_state;

  assign blk       = vc.d0_pause | vc.d1_pause;
  assign serving1  = (state_q == ARB_SERVE1);
  assign cur_empty = serving1 ? vc.vc1_empty : vc.vc0_empty;
  assign oth_empty = serving1 ? vc.vc0_empty : vc.vc1_empty;
  assign cur_w     = serving1 ? w1_q : w0_q;
  assign oth_hit   = serving1 ? hit[VC0] : hit[VC1];
  assign oth_state = serving1 ? ARB_SERVE0 : ARB_SERVE1;
  assign burst_inc = burst_q + WEIGHT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      burst_q  <= '0;
      w0_q     <= WEIGHT_W'(1);
      w1_q     <= WEIGHT_W'(1);
      starve_q <= 1'b0;
      pops0_q  <= '0;
      pops1_q  <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      starve_q <= starve_d;
      pops0_q  <= pops0_d;
      pops1_q  <= pops1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    starve_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (enable && !(vc.vc0_empty && vc.vc1_empty)) begin
          state_d = vc.vc0_empty ? ARB_SERVE1 : ARB_SERVE0;
          burst_d = '0;
          w0_d    = (weight_vc0 == '0) ? WEIGHT_W'(1) : weight_vc0;
          w1_d    = (weight_vc1 == '0) ? WEIGHT_W'(1) : weight_vc1;
        end
      end
      ARB_SERVE0, ARB_SERVE1: begin
        // Starvation preemption wins even while D0/D1 are paused.
        if (enable && oth_hit && !oth_empty) begin
          state_d  = oth_state;
          burst_d  = '0;
          starve_d = 1'b1;
        end else if (!enable) begin
          state_d = ARB_IDLE;
        end else if (blk) begin
          state_d = state_q;
        end else if (cur_empty && oth_empty) begin
          state_d = ARB_IDLE;
        end else if (cur_empty) begin
          state_d = oth_state;
          burst_d = '0;
        end else if (burst_inc == cur_w) begin
          burst_d = '0;
          if (!oth_empty) begin
            state_d = oth_state;
          end
        end else begin
          burst_d = burst_inc;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    pop0    = enable & ~blk & (state_q == ARB_SERVE0) & ~vc.vc0_empty;
    pop1    = enable & ~blk & (state_q == ARB_SERVE1) & ~vc.vc1_empty;
    pops0_d = pops0_q + CNT_W'(pop0);
    pops1_d = pops1_q + CNT_W'(pop1);
  end

  assign inc[VC0] = enable & ~vc.vc0_empty & (state_q != ARB_SERVE0);
  assign inc[VC1] = enable & ~vc.vc1_empty & (state_q != ARB_SERVE1);
  assign clr[VC0] = (state_d == ARB_SERVE0) & (state_q != ARB_SERVE0);
  assign clr[VC1] = (state_d == ARB_SERVE1) & (state_q != ARB_SERVE1);

  vc_wait_counter #(.LIMIT(STARVE_LIMIT)) u_wait_vc0 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr[VC0]),
    .inc   (inc[VC0]),
    .hit   (hit[VC0])
  );

  vc_wait_counter #(.LIMIT(STARVE_LIMIT)) u_wait_vc1 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr[VC1]),
    .inc   (inc[VC1]),
    .hit   (hit[VC1])
  );

  assign vc.pop_VC0 = pop0;
  assign vc.pop_VC1 = pop1;
  assign arb_state  = state_q;
  assign starve_evt = starve_q;
  assign pops_vc0   = pops0_q;
  assign pops_vc1   = pops1_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// tb/tb_vc_arbiter.sv - scoreboard bench for the VC pop arbiter
module tb_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] weight_vc0, weight_vc1;
  logic [1:0] arb_state;
  logic       starve_evt;
  logic [7:0] pops_vc0, pops_vc1;

  vc_arbiter_if vif ();

  vc_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .weight_vc0 (weight_vc0),
    .weight_vc1 (weight_vc1),
    .vc         (vif),
    .arb_state  (arb_state),
    .starve_evt (starve_evt),
    .pops_vc0   (pops_vc0),
    .pops_vc1   (pops_vc1)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int occ0, occ1;
  int starve_cnt;
  logic en_s, p0_s, p1_s;
  logic [3:0] w0_s, w1_s;
  int sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    enable        = en_s;
    vif.d0_pause  = p0_s;
    vif.d1_pause  = p1_s;
    weight_vc0    = w0_s;
    weight_vc1    = w1_s;
    vif.vc0_empty = (occ0 == 0);
    vif.vc1_empty = (occ1 == 0);
  endtask

  task automatic cycle();
    int exp_vc;
    @(negedge clk);
    drive();
    #1;
    check("dual_pop", {31'd0, vif.pop_VC0 & vif.pop_VC1}, 0);
    check("pop_on_empty", {31'd0, (vif.pop_VC0 & vif.vc0_empty) | (vif.pop_VC1 & vif.vc1_empty)}, 0);
    if (vif.pop_VC0 || vif.pop_VC1) begin
      if (sb.size() == 0) begin
        check("extra_pop", {31'd0, vif.pop_VC0 | vif.pop_VC1}, 0);
      end else begin
        exp_vc = sb.pop_front();
        check("pop_vc", {31'd0, vif.pop_VC1}, exp_vc);
      end
    end
    if (starve_evt) starve_cnt++;
    if (vif.pop_VC0 && occ0 > 0) occ0--;
    if (vif.pop_VC1 && occ1 > 0) occ1--;
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_left", sb.size(), 0);
    sb.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    drive();
    @(negedge clk);
    drive();
    #1;
    reset = 1'b1;
    starve_cnt = 0;
  endtask

  task automatic setup(input logic [3:0] w0, input logic [3:0] w1, input int o0, input int o1);
    en_s = 1'b1; p0_s = 1'b0; p1_s = 1'b0;
    w0_s = w0; w1_s = w1;
    occ0 = o0; occ1 = o1;
    sb.delete();
  endtask

  initial begin
    // Reset held with VC0 non-empty and enable high
    setup(4'd4, 4'd1, 5, 0);
    reset = 1'b0;
    drive();
    repeat (3) begin
      @(negedge clk);
      drive();
      #1;
      check("rst_pop0", {31'd0, vif.pop_VC0}, 0);
      check("rst_pop1", {31'd0, vif.pop_VC1}, 0);
      check("rst_state", {30'd0, arb_state}, 0);
      check("rst_pops0", {24'd0, pops_vc0}, 0);
      check("rst_starve", {31'd0, starve_evt}, 0);
    end
    reset = 1'b1;
    starve_cnt = 0;
    repeat (5) sb.push_back(0);
    cycle();
    check("rst_exit_serve0", {30'd0, arb_state}, 1);
    run_drain(10);
    cycle();
    cycle();
    check("rst_drained_idle", {30'd0, arb_state}, 0);

    // Weighted pattern 0,0,0,1
    setup(4'd3, 4'd1, 1000, 1000);
    repeat (10) begin
      sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(1);
    end
    apply_reset();
    run_drain(60);
    en_s = 1'b0;
    cycle();
    check("w_pops0", {24'd0, pops_vc0}, 30);
    check("w_pops1", {24'd0, pops_vc1}, 10);
    check("w_no_starve", starve_cnt, 0);
    cycle();
    check("w_idle", {30'd0, arb_state}, 0);

    // Backpressure freezes the burst count
    setup(4'd4, 4'd1, 1000, 0);
    sb.push_back(0); sb.push_back(0);
    apply_reset();
    run_drain(10);
    p1_s = 1'b1;
    repeat (5) begin
      cycle();
      check("bp_state", {30'd0, arb_state}, 1);
    end
    p1_s = 1'b0;
    occ1 = 10;
    sb.push_back(0); sb.push_back(0); sb.push_back(1);
    sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(1);
    run_drain(20);
    check("bp_pops0", {24'd0, pops_vc0}, 8);

    // Starvation preempts a long VC0 burst
    setup(4'd15, 4'd1, 1000, 1000);
    repeat (8) sb.push_back(0);
    sb.push_back(1);
    apply_reset();
    run_drain(20);
    check("starve_state", {30'd0, arb_state}, 2);
    en_s = 1'b0;
    cycle();
    check("starve_once", starve_cnt, 1);

    // Empty handoff: 2 VC0 entries, 4 VC1 entries
    setup(4'd4, 4'd4, 2, 4);
    sb.push_back(0); sb.push_back(0);
    repeat (4) sb.push_back(1);
    apply_reset();
    run_drain(20);
    cycle();
    cycle();
    check("ho_idle", {30'd0, arb_state}, 0);
    check("ho_pops0", {24'd0, pops_vc0}, 2);
    check("ho_pops1", {24'd0, pops_vc1}, 4);

    // Zero weights behave as one
    setup(4'd0, 4'd0, 1000, 1000);
    repeat (3) begin
      sb.push_back(0); sb.push_back(1);
    end
    apply_reset();
    run_drain(20);

    // Counter wrap, then enable drop mid-burst
    setup(4'd5, 4'd1, 1000, 0);
    repeat (257) sb.push_back(0);
    apply_reset();
    run_drain(300);
    en_s = 1'b0;
    cycle();
    check("en_drop_pop", {31'd0, vif.pop_VC0}, 0);
    check("en_drop_state", {30'd0, arb_state}, 1);
    check("wrap_pops0", {24'd0, pops_vc0}, 1);
    cycle();
    check("en_drop_idle", {30'd0, arb_state}, 0);
    check("wrap_hold", {24'd0, pops_vc0}, 1);

    // Reset asserted mid-burst kills the pop at once
    en_s = 1'b1;
    repeat (3) sb.push_back(0);
    run_drain(10);
    @(negedge clk);
    drive();
    #1;
    check("pre_rst_pop", {31'd0, vif.pop_VC0}, 1);
    check("pre_rst_pops0", {24'd0, pops_vc0}, 4);
    reset = 1'b0;
    #1;
    check("mid_rst_pop", {31'd0, vif.pop_VC0}, 0);
    check("mid_rst_state", {30'd0, arb_state}, 0);
    check("mid_rst_pops0", {24'd0, pops_vc0}, 0);
    @(negedge clk);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Weighted round-robin scheduler that sequences pops from the two virtual-channel FIFOs (VC0, VC1) into the destination mux/demux path.
- Replaces the fixed-priority pop equations at the transaction-layer top level.
- Honours D0/D1 backpressure, weight-bounded bursts, a starvation guard, and the enable coming from the init/idle/active state machine.
- Exports per-VC pop counters and arbitration status for the bench.

Parameters:
- WEIGHT_W, 4, width of the weight inputs.
- STARVE_LIMIT, 8, number of waiting cycles after which a non-empty, unserved VC preempts the current burst.
- CNT_W, 8, width of the per-VC pop statistic counters.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  arbitration allowed (driven from the state machine's active output).
- vc0_empty  input  1  VC0 FIFO empty.
- vc1_empty  input  1  VC1 FIFO empty.
- d0_pause  input  1  D0 FIFO pause (almost-full threshold).
- d1_pause  input  1  D1 FIFO pause.
- weight_vc0  input  WEIGHT_W  maximum consecutive VC0 pops per burst.
- weight_vc1  input  WEIGHT_W  maximum consecutive VC1 pops per burst.
- pop_VC0  output  1  pop strobe to VC0.
- pop_VC1  output  1  pop strobe to VC1.
- arb_state  output  2  current state encoding.
- starve_evt  output  1  one-cycle pulse when a starvation preemption occurs.
- pops_vc0  output  CNT_W  total VC0 pops, wraps modulo 2^CNT_W.
- pops_vc1  output  CNT_W  total VC1 pops, wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, burst counter=0, both wait counters=0.
  - Latched weights=1.
  - pops_vc0=pops_vc1=0, starve_evt=0, pop_VC0=pop_VC1=0.
- State encoding: IDLE=2'd0, SERVE0=2'd1, SERVE1=2'd2; 2'd3 is illegal and recovers to IDLE on the next clock.
- Pop strobe equations (combinational from the registered state plus live inputs, so a pop is never issued on an empty FIFO in the same cycle):
  - blk = d0_pause | d1_pause.
  - pop_VC0 = enable & !blk & state==SERVE0 & !vc0_empty.
  - pop_VC1 = enable & !blk & state==SERVE1 & !vc1_empty.
  - Data appears at the mux one cycle after the pop via the FIFO valid_read; the arbiter does not track it.
- Weights:
  - Sampled into internal registers only on IDLE->SERVEx transitions, so a weight change mid-burst has no effect until the next IDLE.
  - A weight value of 0 is treated as 1.
- IDLE:
  - Stays while enable=0 or both VCs are empty.
  - Otherwise moves to SERVE0 if VC0 is non-empty, else SERVE1. VC0 wins a tie, but only from IDLE.
  - Burst counter cleared on leaving IDLE.
- SERVEx:
  - Burst counter increments on each pop of VCx.
  - Switch to the other VC (SERVEy, counter cleared) when any of these holds:
    - counter reaches its weight on this pop and VCy is non-empty;
    - VCx is empty and VCy is non-empty.
  - If both VCs are empty, or enable=0, go to IDLE.
  - If the burst limit is reached and VCy is empty, stay in SERVEx and clear the counter (new burst).
  - A blk cycle freezes the counter and the state.
- Starvation guard:
  - wait_y increments each cycle VCy is non-empty, the state is not SERVEy, and enable=1; it saturates at STARVE_LIMIT.
  - wait_y clears on entry to SERVEy.
  - When wait_y==STARVE_LIMIT, force a switch to SERVEy next cycle regardless of the burst count, and pulse starve_evt for one cycle.
  - Preemption takes precedence over all other SERVE transitions.
- Counters: pops_vcx increments on each pop_VCx=1 cycle and wraps modulo 2^CNT_W with no flag.
- Simultaneous events: blk=1 together with a starvation hit still performs the switch; wait counters keep running during blk.
- Dropping enable mid-burst: pops stop in the same cycle (combinational); the state returns to IDLE next clock; counters hold.
- Reset asserted mid-burst: pops drop immediately (asynchronous) and all registers return to reset values.

Decomposition:
- Shared package: state encodings (IDLE/SERVE0/SERVE1), the default STARVE_LIMIT, and the VC index constants.
- One natural sub-module: vc_wait_counter, a saturating wait counter with clear/inc/hit. Instantiate it twice, once per VC.

Test Plan:
- Reset: hold reset=0 for 3 clocks with VC0 non-empty -> pop_VC0=pop_VC1=0, arb_state=0, pops_vc0=0; after release with enable=1 -> SERVE0 on the next clock.
- Weights: weight_vc0=3, weight_vc1=1, both VCs continuously non-empty, no pause -> pop pattern 0,0,0,1,0,0,0,1...; after 40 pops, pops_vc0=30 and pops_vc1=10.
- Backpressure: d1_pause=1 for 5 cycles mid-burst -> no pops for those cycles, burst counter frozen, burst resumes afterwards with the remaining count.
- Starvation: weight_vc0=15, STARVE_LIMIT=8, VC1 non-empty from cycle 0 -> switch to SERVE1 after 8 waiting cycles, starve_evt pulses exactly once.
- Empty handoff: VC0 holds 2 entries, VC1 holds 4, weight_vc0=4 -> 2 VC0 pops, then an immediate switch and 4 VC1 pops, then IDLE; no pop ever issued on an empty FIFO.
- Wrap and enable: CNT_W=8, drive 257 VC0 pops -> pops_vc0=1; drop enable mid-burst -> pops stop in the same cycle, arb_state=0 next clock.
